inst_fetch_queue: RTL
=====================

# inst_fetch_queue

Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word fetches to an instruction memory with a valid/ready request channel and a variable-latency response. Returned instructions are buffered with their PC in a small FIFO. It presents {pc, pc+4, inst} to decode, honours hazard stalls, and discards all buffered and in-flight work on a branch/jump redirect.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- redirect_valid  in  1  branch/jump taken in ID; flush and refetch.
- redirect_pc  in  32  new fetch target; word aligned.
- stall  in  1  decode cannot accept this cycle (hazard unit).
- if_valid  out  1  head entry valid for decode.
- if_pc  out  32  PC of the head entry; 0 when empty.
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32; 0 when empty.
- if_inst  out  32  head instruction; 0 when empty.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  32  fetch address; equals fetch_pc.
- imem_req_ready  in  1  memory accepts the request.
- imem_resp_valid  in  1  response strobe, one cycle per accepted request.
- imem_resp_inst  in  32  fetched word.

## Operation
- State: fetch_pc[31:0], FIFO (DEPTH × {pc, inst}), count, outstanding (0/1), req_pc (PC of the outstanding request), drop flag.
- At most one outstanding request. A response always arrives at least one cycle after acceptance.
- issue = rst && !redirect_valid && (!outstanding || imem_resp_valid) && (count + outstanding < DEPTH). count is the registered value; no credit is taken for a same-cycle pop.
- imem_req_valid = issue. On acceptance (valid && ready): req_pc ← fetch_pc, fetch_pc ← fetch_pc + 4, outstanding ← 1.
- While ready is low, valid and addr are held stable. The only exception is a redirect, which withdraws the request.
- Response with drop = 0: push {req_pc, imem_resp_inst}, outstanding ← 0, unless a new request is accepted in the same cycle.
- Response with drop = 1: the word is discarded, drop ← 0, outstanding ← 0.
- A response while outstanding = 0 is ignored.
- Pop: if_valid && !stall advances the head. Push and pop in the same cycle are legal, and count is unchanged.
- Redirect has highest priority. The FIFO empties (count ← 0), fetch_pc ← redirect_pc, and no request issues that cycle.
  - If outstanding = 1 and no response arrives this cycle: drop ← 1.
  - A response arriving in the redirect cycle is discarded and clears outstanding.
  - The pop in the redirect cycle still counts as consumed.
- Outputs come combinationally from the head entry (show-ahead).
- Pointers wrap modulo DEPTH.

## Timing
- Reset (rst = 0 at an edge): fetch_pc = RESET_PC; count, outstanding, drop = 0. While rst = 0: if_valid = 0, imem_req_valid = 0, if_pc/if_pc_plus4/if_inst = 0.
- Zero-wait memory (ready = 1, response one cycle later):
  - First rst = 1 cycle T0: request for RESET_PC.
  - T1: response, plus request for RESET_PC+4.
  - T2: if_valid = 1 with RESET_PC.
  - Steady throughput: 1 instruction/cycle.
- Redirect at cycle t with no drop pending: request for redirect_pc at t+1; earliest if_valid at t+3.
- Redirect at cycle t with drop pending: the request waits for the dropped response's cycle (the response and the new request may share that cycle).
- Full: count + outstanding == DEPTH holds imem_req_valid low until a pop.
- stall held with if_valid = 1: head outputs are stable.

## Test plan
- Reset, zero-wait memory returning inst = addr ^ 32'hA5A5_A5A5, stall = 0 → if_pc = 0, 4, 8, … on consecutive cycles from T2; if_pc_plus4 = if_pc + 4.
- stall = 1 for 10 cycles → FIFO fills to DEPTH = 4 with imem_req_valid = 0 and head fixed at PC 0. Release → PCs 0, 4, 8, 12, 16 delivered without gaps or duplicates.
- Memory latency 3 cycles, redirect to 0x100 while a request for 0x10 is outstanding → the 0x10 word is never delivered; next if_pc = 0x100.
- Redirect in the same cycle as imem_resp_valid → that word is discarded; the request for redirect_pc issues the next cycle.
- imem_req_ready low for 5 cycles → imem_req_addr held constant and fetch_pc does not advance; the fetch then resumes at the same address.
- rst = 0 for one cycle mid-stream with 3 entries queued → if_valid = 0 the next cycle; the first request after release is RESET_PC; a stale response arriving after reset is ignored.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, keeps one request in flight to
// instruction memory and buffers returned words with their PC for decode (show-ahead).
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_inst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_inst
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          outstanding;
    logic          drop;

    logic          resp_take;
    logic          issue;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;

    // The in-flight request reserves a slot so its response always has room.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, outstanding};
    assign resp_take = outstanding && imem_resp_valid;
    assign issue     = rst && !redirect_valid && (!outstanding || imem_resp_valid)
                       && (occupancy < (CW+1)'(DEPTH));
    assign accept    = issue && imem_req_ready;
    assign push      = rst && !redirect_valid && resp_take && !drop;
    assign pop       = if_valid && !stall;

    assign imem_req_valid = issue;
    assign imem_req_addr  = fetch_pc;

    assign if_valid    = rst && (count != '0);
    assign if_pc       = if_valid ? pc_mem[head] : '0;
    assign if_pc_plus4 = if_valid ? pc_mem[head] + 32'd4 : '0;
    assign if_inst     = if_valid ? inst_mem[head] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= req_pc;
            inst_mem[tail] <= imem_resp_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (redirect_valid) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc;
            // A request still in flight must have its word thrown away when it lands.
            if (outstanding && !imem_resp_valid) begin
                drop <= 1'b1;
            end else if (outstanding) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
        end else begin
            if (resp_take) begin
                outstanding <= 1'b0;
                if (drop) begin
                    drop <= 1'b0;
                end
            end
            if (accept) begin
                outstanding <= 1'b1;
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
